pts_tx_ctrl: RTL and testbench
==============================

// Module: pts_tx_ctrl
// PURPOSE
//  Sequencer for a flexible parallel-to-serial shift register (PTS SR) on the transmit path.
//  - Accepts words over a valid/ready handshake into a one-entry holding buffer.
//  - Drives the SR's load/shift enables at one bit per CLKS_PER_BIT clocks.
//  - Chains words back-to-back with no idle bit between them.
//  - Returns the line to idle-high (SR shifts in 1s) when no word is pending, and supports abort.
// PARAMETERS
//  NUM_BITS      8  word width; must match the SR's NUM_BITS (>=2)
//  CLKS_PER_BIT  8  clocks per serial bit period (>=1)
// PORTS
//  clk        in   1         system clock, all state on rising edge
//  n_rst      in   1         asynchronous, active-low reset
//  in_data    in   NUM_BITS  word to transmit
//  in_valid   in   1         in_data valid
//  in_ready   out  1         holding buffer empty; word accepted when in_valid&&in_ready
//  abort      in   1         sync abort: drop current + buffered word, force line idle
//  pts_load   out  1         to SR load_enable
//  pts_shift  out  1         to SR shift_enable
//  pts_data   out  NUM_BITS  to SR parallel_in
//  busy       out  1         word buffered or being shifted
//  word_done  out  1         1-cycle pulse at end of a word's last bit period
// BEHAVIOUR
//  - Reset: state=IDLE, buf_full=0, buf='1, bit_timer=0, bit_cnt=0.
//    Outputs during/after reset: pts_load=0, pts_shift=0, pts_data='1, in_ready=1, busy=0, word_done=0.
//  - Output timing: all outputs are combinational decodes of registered state in the same cycle.
//    in_ready=!buf_full; busy=(state!=IDLE)||buf_full; pts_data=abort?'1:buf.
//  - Accept: in_valid&&in_ready at edge -> buf<=in_data, buf_full<=1.
//    Legal in any state except the cycle abort=1.
//  - States:
//    IDLE:  if buf_full -> pts_load=1, buf_full<=0, timer<=0, bit_cnt<=0, go SHIFT.
//           Accept at T -> load at T+1 -> first bit on line at T+2.
//    SHIFT: bit_timer counts 0..CLKS_PER_BIT-1 and wraps; period end = bit_timer==CLKS_PER_BIT-1.
//      - Period end, bit_cnt<NUM_BITS-1: pts_shift=1, bit_cnt++.
//      - Period end, bit_cnt==NUM_BITS-1: word_done=1, then:
//          buf_full -> pts_load=1 (no shift), buf_full<=0, bit_cnt<=0, stay SHIFT;
//          else     -> pts_shift=1 (line goes idle-high), go IDLE.
//      - Every word produces exactly NUM_BITS enables (NUM_BITS-1 shifts plus a final shift or load).
//  - pts_load and pts_shift are never high in the same cycle.
//  - Abort (any state; wins over all other events): pts_load=1, pts_data='1, buf_full<=0,
//    counters<=0, state<=IDLE, no word_done; an in_valid that cycle is not accepted.
//  - Accept during the consuming cycle cannot occur (in_ready=0 while buf_full).
//  - Reset mid-word: immediate return to reset values, no enable pulses; word lost.
//  - Widths: bit_timer $clog2(CLKS_PER_BIT) bits (min 1), bit_cnt $clog2(NUM_BITS) bits; no overflow past terminal values.
// TESTING (NUM_BITS=8, CLKS_PER_BIT=4 unless noted)
//  1 reset: assert n_rst mid-cycle -> pts_load=0, pts_shift=0, pts_data=8'hFF, in_ready=1, busy=0 with no clock edge
//  2 single: accept 8'hA5 at T -> pts_load+pts_data=A5 at T+1; pts_shift at T+5,9,..,33 (8 pulses); word_done T+33; busy=0 at T+34
//  3 back-to-back: A5 at T, 3C at T+2 -> in_ready=0 T+3..T+33; T+33 pts_load (pts_shift=0) data 3C + word_done; next shift T+37
//  4 abort: A5 at T, 3C at T+2, abort at T+10 -> T+10 pts_load=1 data FF; T+11 idle, in_ready=1, busy=0; no word_done ever
//  5 reset mid-word: n_rst low at T+12 during A5 -> all outputs to reset values; after release no enables until new accept
//  6 CLKS_PER_BIT=1: accept 8'h81 at T -> load T+1, pts_shift every cycle T+2..T+9, word_done T+9, IDLE at T+10

Source files
------------

// File: rtl/pts_tx_ctrl.sv
// Transmit-side sequencer for a parallel-to-serial shift register: buffers one word,
// then paces the SR's load/shift enables at one bit per CLKS_PER_BIT clocks.
module pts_tx_ctrl #(
    parameter int NUM_BITS     = 8,
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                abort,
    output logic                pts_load,
    output logic                pts_shift,
    output logic [NUM_BITS-1:0] pts_data,
    output logic                busy,
    output logic                word_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(NUM_BITS);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(NUM_BITS - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e                state_q, state_d;
    logic                  buf_full_q, buf_full_d;
    logic [NUM_BITS-1:0]   buf_q, buf_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  load_c, shift_c, done_c;
    logic                  period_end;

    assign period_end = (state_q == SHIFT) && (timer_q == TIMER_LAST);

    always_comb begin
        // NOTE: every signal gets a default up front so no path leaves it unassigned (no latches).
        state_d    = state_q;
        buf_full_d = buf_full_q;
        buf_d      = buf_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        done_c     = 1'b0;

        if (abort) begin
            // Loading all-ones forces the line idle-high immediately.
            load_c     = 1'b1;
            buf_full_d = 1'b0;
            timer_d    = '0;
            cnt_d      = '0;
            state_d    = IDLE;
        end else begin
            if (in_valid && !buf_full_q) begin
                buf_d      = in_data;
                buf_full_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (buf_full_q) begin
                        load_c     = 1'b1;
                        buf_full_d = 1'b0;
                        timer_d    = '0;
                        cnt_d      = '0;
                        state_d    = SHIFT;
                    end
                end
                SHIFT: begin
                    timer_d = period_end ? '0 : timer_q + 1'b1;
                    if (period_end) begin
                        if (cnt_q != CNT_LAST) begin
                            shift_c = 1'b1;
                            cnt_d   = cnt_q + 1'b1;
                        end else begin
                            done_c = 1'b1;
                            cnt_d  = '0;
                            // A pending word replaces the last shift so words chain with no gap.
                            if (buf_full_q) begin
                                load_c     = 1'b1;
                                buf_full_d = 1'b0;
                            end else begin
                                shift_c = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            buf_full_q <= 1'b0;
            buf_q      <= '1;
            timer_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_full_q <= buf_full_d;
            buf_q      <= buf_d;
            timer_q    <= timer_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = !buf_full_q;
    assign busy      = (state_q != IDLE) || buf_full_q;
    assign pts_data  = abort ? '1 : buf_q;
    assign pts_load  = load_c;
    assign pts_shift = shift_c;
    assign word_done = done_c;

endmodule

// File: tb/tb_pts_tx_ctrl.sv
// Directed bench for pts_tx_ctrl: table-driven cycle vectors (CLKS_PER_BIT=4)
// plus hand-written reset and CLKS_PER_BIT=1 sequences.
module tb_pts_tx_ctrl;

    typedef struct {
        logic        valid;
        logic [7:0]  din;
        logic        abort;
        logic [12:0] exp;   // {load, shift, data[7:0], ready, busy, done}
    } vec_t;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       abort = 1'b0;
    logic       in_ready, pts_load, pts_shift, busy, word_done;
    logic [7:0] pts_data;

    logic [7:0] in_data2 = 8'h00;
    logic       in_valid2 = 1'b0;
    logic       abort2 = 1'b0;
    logic       in_ready2, pts_load2, pts_shift2, busy2, word_done2;
    logic [7:0] pts_data2;

    logic [12:0] outs, outs2;
    assign outs  = {pts_load, pts_shift, pts_data, in_ready, busy, word_done};
    assign outs2 = {pts_load2, pts_shift2, pts_data2, in_ready2, busy2, word_done2};

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[64];
    int   nvec;

    pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .n_rst(n_rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .abort(abort), .pts_load(pts_load),
        .pts_shift(pts_shift), .pts_data(pts_data), .busy(busy), .word_done(word_done)
    );

    pts_tx_ctrl #(.NUM_BITS(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .n_rst(n_rst), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .abort(abort2), .pts_load(pts_load2),
        .pts_shift(pts_shift2), .pts_data(pts_data2), .busy(busy2), .word_done(word_done2)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] mk(logic l, logic s, logic [7:0] d,
                                       logic r, logic b, logic w);
        return {l, s, d, r, b, w};
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got {ld,sh,data,rdy,busy,done}=%b_%b_%h_%b_%b_%b want %b_%b_%h_%b_%b_%b",
                     name, got[12], got[11], got[10:3], got[2], got[1], got[0],
                     want[12], want[11], want[10:3], want[2], want[1], want[0]);
        end
    endtask

    task automatic reset_dut();
        in_valid = 1'b0; abort = 1'b0; in_valid2 = 1'b0; abort2 = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    // Cycle i: inputs driven just after a rising edge, outputs checked on the falling edge.
    task automatic run_vecs(input string name);
        for (int i = 0; i < nvec; i++) begin
            @(posedge clk);
            #1;
            in_valid = vecs[i].valid;
            in_data  = vecs[i].din;
            abort    = vecs[i].abort;
            @(negedge clk);
            check($sformatf("%s[%0d]", name, i), outs, vecs[i].exp);
        end
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        // Reset asserted between clock edges must take effect with no edge.
        #2 n_rst = 1'b0;
        #1;
        check("reset_async", outs, mk(0, 0, 8'hFF, 1, 0, 0));
        check("reset_async_cpb1", outs2, mk(0, 0, 8'hFF, 1, 0, 0));
        @(negedge clk);
        n_rst = 1'b1;

        // Single word A5: load at 1, shifts at 5,9,..,33, done at 33, idle at 34.
        reset_dut();
        nvec = 35;
        for (int i = 0; i < nvec; i++) begin
            vecs[i].valid = (i == 0);
            vecs[i].din   = 8'hA5;
            vecs[i].abort = 1'b0;
            vecs[i].exp   = mk(i == 1, (i >= 5) && (i <= 33) && ((i - 5) % 4 == 0),
                               (i == 0) ? 8'hFF : 8'hA5, i != 1,
                               (i >= 1) && (i <= 33), i == 33);
        end
        run_vecs("single");

        // Back-to-back A5 then 3C: chained load at 33 with no shift, next shift at 37.
        reset_dut();
        nvec = 39;
        for (int i = 0; i < nvec; i++) begin
            vecs[i].valid = (i == 0) || (i == 2);
            vecs[i].din   = (i == 0) ? 8'hA5 : 8'h3C;
            vecs[i].abort = 1'b0;
            vecs[i].exp   = mk((i == 1) || (i == 33),
                               ((i >= 5) && (i <= 29) && ((i - 5) % 4 == 0)) || (i == 37),
                               (i == 0) ? 8'hFF : (i <= 2) ? 8'hA5 : 8'h3C,
                               (i == 0) || (i == 2) || (i >= 34),
                               i >= 1, i == 33);
        end
        run_vecs("b2b");

        // Abort at 10 drops both words; a second abort at 12 with in_valid must not accept 5A.
        reset_dut();
        nvec = 16;
        for (int i = 0; i < nvec; i++) begin
            vecs[i].valid = (i == 0) || (i == 2) || (i == 12);
            vecs[i].din   = (i == 0) ? 8'hA5 : (i == 2) ? 8'h3C : 8'h5A;
            vecs[i].abort = (i == 10) || (i == 12);
            vecs[i].exp   = mk((i == 1) || (i == 10) || (i == 12), (i == 5) || (i == 9),
                               (i == 0) ? 8'hFF : (i <= 2) ? 8'hA5 :
                               ((i == 10) || (i == 12)) ? 8'hFF : 8'h3C,
                               (i == 0) || (i == 2) || (i >= 11),
                               (i >= 1) && (i <= 10), 1'b0);
        end
        run_vecs("abort");

        // Reset mid-word: outputs return to reset values at once, then stay quiet.
        reset_dut();
        for (int i = 0; i <= 12; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 0);
            in_data  = 8'hA5;
        end
        #2 n_rst = 1'b0;
        #1;
        check("reset_midword", outs, mk(0, 0, 8'hFF, 1, 0, 0));
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("after_reset[%0d]", i), outs, mk(0, 0, 8'hFF, 1, 0, 0));
        end

        // CLKS_PER_BIT=1: load at 1, shift every cycle 2..9, done at 9, idle at 10.
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            in_valid2 = (i == 0);
            in_data2  = 8'h81;
            @(negedge clk);
            check($sformatf("cpb1[%0d]", i), outs2,
                  mk(i == 1, (i >= 2) && (i <= 9), (i == 0) ? 8'hFF : 8'h81,
                     i != 1, (i >= 1) && (i <= 9), i == 9));
        end
        in_valid2 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
